spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
- SPI responder (slave) for the byte-wide SPI bus: CS, SCLK, 8-bit MOSI and 8-bit MISO.
- Holds a 2**ADDR_W x 8 register file.
- Frame format: one command byte, then one or more data bytes with auto-increment.
- Sits on the DUT side of the bus. Local logic accesses the same register file through a host port.

Parameters:
- ADDR_W, 4, register address width (1..7); register file depth is 2**ADDR_W.
- SYNC_STAGES, 2, synchronizer flops on CS/SCLK/MOSI (>=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- CS  input  1  SPI chip select, active low.
- SCLK  input  1  SPI clock, CPOL=0/CPHA=0, asynchronous to clk.
- MOSI  input  8  SPI master-to-slave byte; sampled on SCLK rise.
- MISO  output  8  SPI slave-to-master byte; changes after SCLK fall.
- hw_we  input  1  host write enable.
- hw_addr  input  ADDR_W  host read/write address.
- hw_wdata  input  8  host write data.
- hw_rdata  output  8  combinational read of regs[hw_addr].
- spi_wr_pulse  output  1  one-cycle pulse on each SPI register write.
- spi_wr_addr  output  ADDR_W  address of that write.
- spi_wr_data  output  8  data of that write.
- busy  output  1  high while a frame is active (synchronized CS low).

Behaviour:
- Reset (rst=0, async):
  - All registers 0x00.
  - Synchronizers: CS=1, SCLK=0, MOSI=0.
  - State IDLE; MISO=0x00; spi_wr_pulse=0; spi_wr_addr=0; spi_wr_data=0; busy=0.
- Synchronization and edge detection:
  - CS, SCLK and MOSI each pass through SYNC_STAGES flops.
  - SCLK rise/fall are detected from the last stage vs. one extra delayed flop.
  - All decisions use synchronized values only.
- Bus timing requirement on the master: SCLK high and low each >= SYNC_STAGES+4 clk cycles; MOSI stable around the SCLK rise.
- State machine: IDLE, CMD, WDATA, RDATA.
  - IDLE -> CMD when synchronized CS is low; ptr=0.
  - CMD, on SCLK rise:
    - Latch ptr = MOSI[ADDR_W-1:0]; bits above ADDR_W and below bit 7 are ignored.
    - MOSI[7]=1 -> RDATA; 0 -> WDATA.
  - WDATA, on each SCLK rise: regs[ptr] <= MOSI; spi_wr_pulse=1 for one cycle with spi_wr_addr=ptr, spi_wr_data=MOSI; ptr <= ptr+1.
  - RDATA, on each SCLK fall: MISO <= regs[ptr]; ptr <= ptr+1. MOSI is ignored on RDATA rises.
  - Any state, synchronized CS high -> IDLE next cycle; MISO <= 0x00; any partial frame is abandoned.
- ptr wraps modulo 2**ADDR_W (e.g. ADDR_W=4: 0xF -> 0x0).
- MISO:
  - 0x00 in IDLE, CMD and WDATA.
  - Registered; updates SYNC_STAGES+2 clk after the SCLK pin fall.
- Register write latency: regs[] and spi_wr_pulse update SYNC_STAGES+2 clk after the SCLK pin rise.
- Host write: hw_we=1 writes hw_wdata to regs[hw_addr] on the clk edge.
- Simultaneous writes:
  - SPI write and host write to the same address in the same cycle: SPI data wins.
  - Different addresses: both writes are performed.
- RDATA read value: MISO samples the register contents at the clk edge that loads MISO, including a host write from an earlier cycle.
- SCLK edges while CS high are ignored.
- SCLK fall in CMD (before any rise) is ignored.
- rst asserted mid-frame: immediate return to reset values. After rst release, a frame resumes only at the next CS fall (synchronized CS must read high at least once first).
- busy = synchronized CS low, registered; reset value 0.

Test Plan:
- Reset then host reads addresses 0..15 -> hw_rdata=0x00 for every address; MISO=0x00; busy=0.
- SPI frame CS low, bytes 0x03,0x11,0x22,0x33 -> regs[3..5]=0x11,0x22,0x33; three spi_wr_pulse pulses with addr 3,4,5; MISO stays 0x00.
- Host writes regs[0xE]=0xAB, regs[0xF]=0xCD, regs[0]=0xEF; SPI read frame 0x8E plus 3 dummy bytes -> MISO after successive falls = 0xAB,0xCD,0xEF (wrap).
- SPI write to addr 7 coincident with host write hw_addr=7, hw_wdata=0x55 while SPI data=0x99 -> regs[7]=0x99.
- CS raised after the command byte 0x05 with no data -> no write; state IDLE; next frame 0x85 reads the old regs[5].
- rst pulsed low mid-write-frame after one data byte -> all regs 0x00, MISO=0x00; the following CS-high-then-low frame works normally.

Source files
------------

// File: rtl/spi_reg_slave_if.sv
// Byte-wide SPI bus: chip select, clock, 8-bit MOSI and 8-bit MISO.
interface spi_reg_slave_if;
  logic       CS;
  logic       SCLK;
  logic [7:0] MOSI;
  logic [7:0] MISO;

  modport master (output CS, output SCLK, output MOSI, input MISO);
  modport slave  (input CS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_reg_slave.sv
// SPI responder holding a 2**ADDR_W x 8 register file. Frame: one command
// byte (bit 7 = read, low bits = start address), then auto-incrementing data
// bytes. A host port reads/writes the same register file; SPI writes win on
// an address collision.
module spi_reg_slave #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_reg_slave_if.slave    spi,
  input  logic              hw_we,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [7:0]        hw_wdata,
  output logic [7:0]        hw_rdata,
  output logic              spi_wr_pulse,
  output logic [ADDR_W-1:0] spi_wr_addr,
  output logic [7:0]        spi_wr_data,
  output logic              busy
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t                            state;
  logic [SYNC_STAGES-1:0]            cs_sync;
  logic [SYNC_STAGES-1:0]            sclk_sync;
  logic [SYNC_STAGES-1:0][7:0]       mosi_sync;
  logic                              sclk_d;
  logic                              rise_q;
  logic                              fall_q;
  logic [7:0]                        mosi_q;
  logic                              cs_s;
  logic                              sclk_s;
  logic [ADDR_W-1:0]                 ptr;
  logic [DEPTH-1:0][7:0]             regs;
  logic [7:0]                        miso_q;
  logic                              spi_we;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign spi_we   = (state == WDATA) && !cs_s && rise_q;
  assign hw_rdata = regs[hw_addr];
  assign spi.MISO = miso_q;

  // Synchronize the SPI pins and register SCLK edge strobes with the MOSI
  // byte that belongs to them, so both reach the FSM in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      mosi_q    <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      sclk_d    <= sclk_s;
      rise_q    <= sclk_s & ~sclk_d;
      fall_q    <= ~sclk_s & sclk_d;
      mosi_q    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  // Register file: host write first, SPI write afterwards so it overrides.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
    end else begin
      if (hw_we)  regs[hw_addr] <= hw_wdata;
      if (spi_we) regs[ptr]     <= mosi_q;
    end
  end

  // Frame state machine with registered MISO, write strobe and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      miso_q       <= '0;
      spi_wr_pulse <= 1'b0;
      spi_wr_addr  <= '0;
      spi_wr_data  <= '0;
      busy         <= 1'b0;
    end else begin
      busy         <= ~cs_s;
      spi_wr_pulse <= 1'b0;
      if (cs_s) begin
        state  <= IDLE;
        miso_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            state  <= CMD;
            ptr    <= '0;
            miso_q <= '0;
          end
          CMD: begin
            miso_q <= '0;
            if (rise_q) begin
              ptr   <= mosi_q[ADDR_W-1:0];
              state <= mosi_q[7] ? RDATA : WDATA;
            end
          end
          WDATA: begin
            miso_q <= '0;
            if (rise_q) begin
              spi_wr_pulse <= 1'b1;
              spi_wr_addr  <= ptr;
              spi_wr_data  <= mosi_q;
              ptr          <= ptr + 1'b1;
            end
          end
          RDATA: begin
            if (fall_q) begin
              miso_q <= regs[ptr];
              ptr    <= ptr + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed frames from the test plan
// plus randomized frames, checked against a frame-level register model.
module tb_spi_reg_slave;
  localparam int unsigned AW   = 4;
  localparam int unsigned SS   = 2;
  localparam int          LAT  = SS + 2;
  localparam int          HALF = 8;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          hw_we;
  logic [AW-1:0] hw_addr;
  logic [7:0]    hw_wdata;
  logic [7:0]    hw_rdata;
  logic          spi_wr_pulse;
  logic [AW-1:0] spi_wr_addr;
  logic [7:0]    spi_wr_data;
  logic          busy;

  spi_reg_slave_if bus ();

  spi_reg_slave #(.ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (bus),
    .hw_we        (hw_we),
    .hw_addr      (hw_addr),
    .hw_wdata     (hw_wdata),
    .hw_rdata     (hw_rdata),
    .spi_wr_pulse (spi_wr_pulse),
    .spi_wr_addr  (spi_wr_addr),
    .spi_wr_data  (spi_wr_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         pulse_cnt = 0;
  logic [7:0] regs_m [16];
  logic [7:0] miso_m;
  logic       busy_m;
  bit         chk_en = 1'b0;
  wr_t        exp_wr [$];
  wr_t        e;
  logic [7:0] tx [$];
  logic [7:0] rd_seen [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!hw_we) hw_addr = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic peek(input string nm, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    hw_addr = a;
    #1;
    chk(nm, 32'(hw_rdata), 32'(exp));
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    hw_we = 1'b1; hw_addr = a; hw_wdata = d;
    regs_m[a] = d;
    @(negedge clk);
    hw_we = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b0;
    bus.CS = 1'b1; bus.SCLK = 1'b0; bus.MOSI = '0;
    for (int k = 0; k < 16; k++) regs_m[k] = '0;
    miso_m = '0; busy_m = 1'b0;
    exp_wr.delete();
    hw_addr = 4'h2;
    #1;
    chk("rst_mid_MISO", 32'(bus.MISO), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_reg2", 32'(hw_rdata), 32'h0);
    tick(3);
    rst = 1'b1;
    tick(LAT + 2);
    chk_en = 1'b1;
    tick(HALF);
  endtask

  // Drives the bytes in tx as one frame and advances the model at the points
  // where each SCLK edge has had time to take effect.
  task automatic spi_frame(input int col_idx, input logic [3:0] col_a,
                           input logic [7:0] col_d, input int rst_at);
    logic [3:0] ptr = '0;
    bit         rd  = 1'b0;
    rd_seen.delete();
    chk_en = 1'b0;
    bus.MOSI = tx[0];
    bus.CS = 1'b0;
    tick(LAT + 2);
    busy_m = 1'b1;
    chk_en = 1'b1;
    tick(HALF - LAT - 2);
    for (int i = 0; i < tx.size(); i++) begin
      chk_en = 1'b0;
      bus.SCLK = 1'b1;
      if (i == 0) begin
        ptr = tx[0][3:0];
        rd  = tx[0][7];
      end else if (!rd) begin
        exp_wr.push_back({ptr, tx[i]});
      end
      if (i == col_idx) begin
        tick(SS + 1);
        hw_we = 1'b1; hw_addr = col_a; hw_wdata = col_d;
        tick(1);
        hw_we = 1'b0;
        tick(LAT - SS);
        regs_m[col_a] = col_d;
      end else begin
        tick(LAT + 2);
      end
      if (i > 0 && !rd) begin
        regs_m[ptr] = tx[i];
        ptr++;
      end
      chk_en = 1'b1;
      tick(HALF - LAT - 2);
      chk_en = 1'b0;
      bus.SCLK = 1'b0;
      if (i + 1 < tx.size()) bus.MOSI = tx[i+1];
      tick(LAT + 2);
      if (rd) begin
        miso_m = regs_m[ptr];
        ptr++;
      end
      chk_en = 1'b1;
      tick(HALF - LAT - 2);
      if (rd) rd_seen.push_back(bus.MISO);
      if (i == rst_at) begin
        do_reset();
        return;
      end
    end
    chk_en = 1'b0;
    bus.CS = 1'b1;
    bus.MOSI = '0;
    tick(LAT + 2);
    miso_m = '0;
    busy_m = 1'b0;
    chk_en = 1'b1;
    tick(HALF);
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      if (spi_wr_pulse) begin
        pulse_cnt++;
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr_pulse: got write addr=%0h data=%0h, required no write", spi_wr_addr, spi_wr_data);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(spi_wr_addr), 32'(e.a));
          chk("wr_data", 32'(spi_wr_data), 32'(e.d));
        end
      end
      if (chk_en) begin
        chk("hw_rdata", 32'(hw_rdata), 32'(regs_m[hw_addr]));
        chk("MISO", 32'(bus.MISO), 32'(miso_m));
        chk("busy", 32'(busy), 32'(busy_m));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.CS = 1'b1; bus.SCLK = 1'b0; bus.MOSI = '0;
    hw_we = 1'b0; hw_addr = '0; hw_wdata = '0;
    for (int k = 0; k < 16; k++) regs_m[k] = '0;
    miso_m = '0; busy_m = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tick(3);
    chk_en = 1'b1;

    for (int a = 0; a < 16; a++) peek("reset_reg", 4'(a), 8'h00);
    chk("reset_MISO", 32'(bus.MISO), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    pulse_cnt = 0;
    tx = '{8'h03, 8'h11, 8'h22, 8'h33};
    spi_frame(-1, 4'h0, 8'h00, -1);
    peek("wr_reg3", 4'h3, 8'h11);
    peek("wr_reg4", 4'h4, 8'h22);
    peek("wr_reg5", 4'h5, 8'h33);
    chk("wr_pulse_count", 32'(pulse_cnt), 32'd3);

    host_wr(4'hE, 8'hAB);
    host_wr(4'hF, 8'hCD);
    host_wr(4'h0, 8'hEF);
    tx = '{8'h8E, 8'h00, 8'h00, 8'h00};
    spi_frame(-1, 4'h0, 8'h00, -1);
    chk("rd_wrap0", 32'(rd_seen[0]), 32'hAB);
    chk("rd_wrap1", 32'(rd_seen[1]), 32'hCD);
    chk("rd_wrap2", 32'(rd_seen[2]), 32'hEF);

    tx = '{8'h07, 8'h99};
    spi_frame(1, 4'h7, 8'h55, -1);
    peek("collide_reg7", 4'h7, 8'h99);

    pulse_cnt = 0;
    tx = '{8'h05};
    spi_frame(-1, 4'h0, 8'h00, -1);
    chk("cmd_only_pulses", 32'(pulse_cnt), 32'd0);
    tx = '{8'h85, 8'h00};
    spi_frame(-1, 4'h0, 8'h00, -1);
    chk("cmd_only_reg5", 32'(rd_seen[0]), 32'h33);

    tx = '{8'h02, 8'h44, 8'h55};
    spi_frame(-1, 4'h0, 8'h00, 1);
    tx = '{8'h0A, 8'h5A};
    spi_frame(-1, 4'h0, 8'h00, -1);
    peek("post_rst_regA", 4'hA, 8'h5A);
    peek("post_rst_reg7", 4'h7, 8'h00);

    repeat (24) begin
      int         len;
      int         col;
      logic [7:0] cmd;
      len = $urandom_range(1, 5);
      cmd = 8'($urandom);
      tx.delete();
      tx.push_back(cmd);
      for (int k = 1; k < len; k++) tx.push_back(8'($urandom));
      col = (!cmd[7] && len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : -1;
      spi_frame(col, 4'($urandom), 8'($urandom), -1);
      if ($urandom_range(0, 1) == 1) host_wr(4'($urandom), 8'($urandom));
    end

    chk("pending_writes", 32'(exp_wr.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
